dct_transpose_buffer: RTL and testbench
=======================================

# dct_transpose_buffer

Ping-pong 8x8 transpose memory between the row-DCT stage and the column-DCT stage of the hierarchical DCT. It accepts one row of eight signed coefficients per handshake beat and, once a full 8x8 block is stored, emits the block one column per beat. Two banks allow one block to be written while the previous block is read, sustaining one beat per cycle in each direction.

## Interface

- SIZE, 10, coefficient width in bits (signed, two's complement)

- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-low reset
- in_valid  input  1  in_row carries a valid row
- in_ready  output  1  buffer can accept a row this cycle
- in_row  input  8*SIZE  row of 8 coefficients; lane k = bits [k*SIZE +: SIZE]
- out_valid  output  1  out_col carries a valid column
- out_ready  input  1  downstream accepts the column this cycle
- out_col  output  8*SIZE  column of 8 coefficients; lane k = element at row k
- out_last  output  1  high with the final column (col 7) of a block

## Operation

- Storage: two banks (0, 1), each 8 rows x 8 lanes x SIZE bits; per-bank full flag.
- Write side: wr_bank (1 bit), wr_row (3 bits).
  - in_ready = !full[wr_bank].
  - Accept when in_valid && in_ready: bank[wr_bank][wr_row][k] <= lane k of in_row; wr_row increments.
  - When wr_row == 7 on accept: full[wr_bank] set, wr_bank toggles, wr_row wraps to 0.
- Read side: rd_bank (1 bit), rd_col (3 bits).
  - out_valid = full[rd_bank].
  - out_col lane k = bank[rd_bank][k][rd_col]; out_last = out_valid && rd_col == 7.
  - Beat when out_valid && out_ready: rd_col increments; when rd_col == 7, full[rd_bank] is cleared, rd_bank toggles, and rd_col wraps to 0.
- Set and clear of the same bank in the same cycle cannot occur because set requires !full and clear requires full. Set of one bank and clear of the other in the same cycle are both applied.
- Data is bit-exact. There is no arithmetic, rounding or saturation, and sign is preserved.
- in_valid with in_ready low does not modify state. The upstream stage holds in_row.
- While out_valid && !out_ready, out_col and out_last hold stable.
- The only state machine is per bank: EMPTY -> FILLING (first row accepted) -> FULL (8th row accepted) -> EMPTY (8th column read).

## Timing

- Reset (rst low, asynchronous): all pointers 0, full flags 0, all storage 0. Outputs: in_ready = 1, out_valid = 0, out_last = 0, out_col = 0.
- Reset asserted mid-block discards any partial or full block. After release, the next accepted row is row 0 of bank 0.
- Latency: the 8th row is accepted on edge N, and out_valid is high in the cycle following edge N, presenting column 0.
- Throughput: with in_valid and out_ready held high, in_ready never deasserts. Output beats are contiguous, one column per cycle, after the first 8-cycle fill.
- Backpressure: with out_ready low, at most 16 rows are accepted. in_ready drops in the cycle after the 16th accept.
- Outputs are driven from registers through the read mux only. There is no combinational path from in_valid or in_row to out_*.
- in_ready depends only on registered state. There is no combinational path from out_ready to in_ready.

## Test plan

- Reset: hold rst low 3 cycles, then release. Required: in_ready = 1, out_valid = 0, out_last = 0, out_col = 0. Drive rst low asynchronously mid-cycle: outputs return to these values immediately.
- Single block: row r lane k = 8r+k, out_ready = 1. Required: out_valid rises the cycle after the 8th accept; column c lane k = 8k+c; out_last is high only on column 7; out_valid drops afterwards.
- Streaming: 3 blocks back-to-back with in_valid and out_ready constantly high. Required: in_ready never low; 24 contiguous output beats starting 8 cycles after the first accept; each block correctly transposed.
- Backpressure: out_ready = 0, drive 17 rows. Required: 16 rows accepted; in_ready = 0 with row 17 held. Raise out_ready for one beat: out_col changes only then. Row 17 is accepted only after bank 0 is fully drained.
- Signed extremes: block of alternating -512 / 511 with SIZE = 10. Required: values emerge bit-exact at transposed positions.
- Mid-block reset: accept 5 rows, pulse rst low, then send a full block of value 7. Required: no output before the new block completes; output is 8 columns of all-7.

Source files
------------

// File: rtl/dct_transpose_buffer_if.sv
// rtl/dct_transpose_buffer_if.sv - row-in / column-out handshake bundle for the transpose buffer
interface dct_transpose_buffer_if #(
    parameter int SIZE = 10
);
    logic                in_valid;
    logic                in_ready;
    logic [8*SIZE-1:0]   in_row;
    logic                out_valid;
    logic                out_ready;
    logic [8*SIZE-1:0]   out_col;
    logic                out_last;

    // Upstream/downstream side (drives rows and column ready)
    modport master (
        output in_valid,
        output in_row,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_col,
        input  out_last
    );

    // Buffer side
    modport slave (
        input  in_valid,
        input  in_row,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_col,
        output out_last
    );
endinterface

// File: rtl/dct_transpose_buffer.sv
// rtl/dct_transpose_buffer.sv - ping-pong 8x8 transpose memory between row and column DCT stages
module dct_transpose_buffer #(
    parameter int SIZE = 10
) (
    input  logic                    clk,
    input  logic                    rst,
    dct_transpose_buffer_if.slave   bus
);

    typedef enum logic [1:0] {
        BANK_EMPTY   = 2'd0,
        BANK_FILLING = 2'd1,
        BANK_FULL    = 2'd2
    } bank_state_e;

    // Storage: [bank][row] holds one packed row of 8 lanes
    logic [8*SIZE-1:0] mem_q [2][8];
    logic [8*SIZE-1:0] mem_d [2][8];

    bank_state_e bank_state_q [2];
    bank_state_e bank_state_d [2];

    logic       wr_bank_q, wr_bank_d;
    logic [2:0] wr_row_q,  wr_row_d;
    logic       rd_bank_q, rd_bank_d;
    logic [2:0] rd_col_q,  rd_col_d;

    logic              in_ready;
    logic              out_valid;
    logic              wr_accept;
    logic              rd_beat;
    logic [8*SIZE-1:0] col_mux;

    // Handshake qualifiers: both come only from registered bank state
    always_comb begin
        in_ready  = (bank_state_q[wr_bank_q] != BANK_FULL);
        out_valid = (bank_state_q[rd_bank_q] == BANK_FULL);
        wr_accept = bus.in_valid && in_ready;
        rd_beat   = out_valid && bus.out_ready;
    end

    // Column read mux: lane k takes element rd_col of stored row k
    always_comb begin
        col_mux = '0;
        for (int k = 0; k < 8; k++) begin
            col_mux[k*SIZE +: SIZE] = mem_q[rd_bank_q][k][int'(rd_col_q)*SIZE +: SIZE];
        end
    end

    // Output drive; column is forced to zero when nothing is presented
    always_comb begin
        bus.in_ready  = in_ready;
        bus.out_valid = out_valid;
        bus.out_col   = out_valid ? col_mux : '0;
        bus.out_last  = out_valid && (rd_col_q == 3'd7);
    end

    // Row write into the bank currently being filled
    always_comb begin
        mem_d = mem_q;
        if (wr_accept) begin
            mem_d[wr_bank_q][wr_row_q] = bus.in_row;
        end
    end

    // Write and read pointers; each bank pointer flips as its block completes
    always_comb begin
        wr_bank_d = wr_bank_q;
        wr_row_d  = wr_row_q;
        rd_bank_d = rd_bank_q;
        rd_col_d  = rd_col_q;
        if (wr_accept) begin
            wr_row_d = wr_row_q + 3'd1;
            if (wr_row_q == 3'd7) begin
                wr_bank_d = ~wr_bank_q;
            end
        end
        if (rd_beat) begin
            rd_col_d = rd_col_q + 3'd1;
            if (rd_col_q == 3'd7) begin
                rd_bank_d = ~rd_bank_q;
            end
        end
    end

    // Per-bank lifecycle: EMPTY -> FILLING -> FULL -> EMPTY
    always_comb begin
        for (int b = 0; b < 2; b++) begin
            bank_state_d[b] = bank_state_q[b];
            case (bank_state_q[b])
                BANK_EMPTY: begin
                    if (wr_accept && (wr_bank_q == 1'(b))) begin
                        bank_state_d[b] = BANK_FILLING;
                    end
                end
                BANK_FILLING: begin
                    if (wr_accept && (wr_bank_q == 1'(b)) && (wr_row_q == 3'd7)) begin
                        bank_state_d[b] = BANK_FULL;
                    end
                end
                BANK_FULL: begin
                    if (rd_beat && (rd_bank_q == 1'(b)) && (rd_col_q == 3'd7)) begin
                        bank_state_d[b] = BANK_EMPTY;
                    end
                end
                default: bank_state_d[b] = BANK_EMPTY;
            endcase
        end
    end

    // State registers; reset discards every stored block and clears storage
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_bank_q <= 1'b0;
            wr_row_q  <= 3'd0;
            rd_bank_q <= 1'b0;
            rd_col_q  <= 3'd0;
            for (int b = 0; b < 2; b++) begin
                bank_state_q[b] <= BANK_EMPTY;
                for (int r = 0; r < 8; r++) begin
                    mem_q[b][r] <= '0;
                end
            end
        end else begin
            wr_bank_q    <= wr_bank_d;
            wr_row_q     <= wr_row_d;
            rd_bank_q    <= rd_bank_d;
            rd_col_q     <= rd_col_d;
            bank_state_q <= bank_state_d;
            mem_q        <= mem_d;
        end
    end

endmodule

// File: tb/tb_dct_transpose_buffer.sv
// tb/tb_dct_transpose_buffer.sv - directed self-checking bench for dct_transpose_buffer
module tb_dct_transpose_buffer;

    localparam int SIZE = 10;

    logic clk;
    logic rst;

    dct_transpose_buffer_if #(.SIZE(SIZE)) bus ();

    dct_transpose_buffer #(.SIZE(SIZE)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int passed;
    int total;

    logic [SIZE-1:0] blk [8][8];

    task automatic check(input string tag, input logic [79:0] obs, input logic [79:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    function automatic logic [79:0] row_of(input int r);
        logic [79:0] v;
        for (int k = 0; k < 8; k++) v[k*SIZE +: SIZE] = blk[r][k];
        return v;
    endfunction

    function automatic logic [79:0] col_of(input int c);
        logic [79:0] v;
        for (int k = 0; k < 8; k++) v[k*SIZE +: SIZE] = blk[k][c];
        return v;
    endfunction

    // Streaming/backpressure block b: element (r,k) = 100*b + 8r + k
    function automatic logic [79:0] s_row(input int b, input int r);
        logic [79:0] v;
        for (int k = 0; k < 8; k++) v[k*SIZE +: SIZE] = SIZE'(100*b + 8*r + k);
        return v;
    endfunction

    function automatic logic [79:0] s_col(input int b, input int c);
        logic [79:0] v;
        for (int k = 0; k < 8; k++) v[k*SIZE +: SIZE] = SIZE'(100*b + 8*k + c);
        return v;
    endfunction

    task automatic send_block(input string tag);
        for (int r = 0; r < 8; r++) begin
            @(negedge clk);
            check({tag, "_pre_valid"}, bus.out_valid, 1'b0);
            check({tag, "_in_ready"}, bus.in_ready, 1'b1);
            bus.in_valid = 1'b1;
            bus.in_row   = row_of(r);
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.in_row   = '0;
    endtask

    task automatic read_block(input string tag);
        bus.out_ready = 1'b1;
        for (int c = 0; c < 8; c++) begin
            check({tag, "_valid"}, bus.out_valid, 1'b1);
            check({tag, "_col"}, bus.out_col, col_of(c));
            check({tag, "_last"}, bus.out_last, (c == 7));
            @(negedge clk);
        end
        check({tag, "_valid_drop"}, bus.out_valid, 1'b0);
    endtask

    initial begin
        passed        = 0;
        total         = 0;
        rst           = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_row    = '0;
        bus.out_ready = 1'b0;

        // Reset held three cycles
        repeat (3) @(negedge clk);
        check("rst_in_ready", bus.in_ready, 1'b1);
        check("rst_out_valid", bus.out_valid, 1'b0);
        check("rst_out_last", bus.out_last, 1'b0);
        check("rst_out_col", bus.out_col, 80'd0);
        rst = 1'b1;

        // Single block: row r lane k = 8r+k
        for (int r = 0; r < 8; r++)
            for (int k = 0; k < 8; k++) blk[r][k] = SIZE'(8*r + k);
        bus.out_ready = 1'b1;
        send_block("single");
        read_block("single");

        // Streaming: three blocks back-to-back
        bus.out_ready = 1'b1;
        for (int t = 0; t <= 32; t++) begin
            @(negedge clk);
            if (t >= 8 && t < 32) begin
                check("stream_valid", bus.out_valid, 1'b1);
                check("stream_col", bus.out_col, s_col((t-8)/8, (t-8)%8));
                check("stream_last", bus.out_last, ((t-8)%8 == 7));
            end else begin
                check("stream_idle", bus.out_valid, 1'b0);
            end
            if (t < 24) begin
                check("stream_in_ready", bus.in_ready, 1'b1);
                bus.in_valid = 1'b1;
                bus.in_row   = s_row(t/8, t%8);
            end else begin
                bus.in_valid = 1'b0;
                bus.in_row   = '0;
            end
        end

        // Backpressure: realign pointers, then 17 rows with out_ready low
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        bus.out_ready = 1'b0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            check("bp_in_ready", bus.in_ready, 1'b1);
            bus.in_valid = 1'b1;
            bus.in_row   = s_row(i/8, i%8);
        end
        @(negedge clk);
        bus.in_row = s_row(2, 0);
        check("bp_full", bus.in_ready, 1'b0);
        check("bp_valid", bus.out_valid, 1'b1);
        check("bp_col0", bus.out_col, s_col(0, 0));
        @(negedge clk);
        check("bp_full_hold", bus.in_ready, 1'b0);
        check("bp_col0_hold", bus.out_col, s_col(0, 0));
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        check("bp_step", bus.out_col, s_col(0, 1));
        check("bp_step_last", bus.out_last, 1'b0);
        @(negedge clk);
        check("bp_col1_hold", bus.out_col, s_col(0, 1));
        check("bp_full_hold2", bus.in_ready, 1'b0);
        bus.out_ready = 1'b1;
        for (int c = 1; c < 8; c++) begin
            check("bp_drain_col", bus.out_col, s_col(0, c));
            check("bp_drain_last", bus.out_last, (c == 7));
            check("bp_drain_in_ready", bus.in_ready, 1'b0);
            @(negedge clk);
        end
        bus.out_ready = 1'b0;
        check("bp_reopen", bus.in_ready, 1'b1);
        check("bp_bank1_col0", bus.out_col, s_col(1, 0));
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.in_row   = '0;
        check("bp_row17_ready", bus.in_ready, 1'b1);
        check("bp_bank1_still", bus.out_valid, 1'b1);

        // Asynchronous reset mid-cycle with a full bank pending
        #2;
        rst = 1'b0;
        #1;
        check("arst_in_ready", bus.in_ready, 1'b1);
        check("arst_out_valid", bus.out_valid, 1'b0);
        check("arst_out_last", bus.out_last, 1'b0);
        check("arst_out_col", bus.out_col, 80'd0);
        @(negedge clk);
        rst = 1'b1;

        // Signed extremes, asymmetric so the transpose is visible
        for (int r = 0; r < 8; r++)
            for (int k = 0; k < 8; k++) blk[r][k] = (k > r) ? 10'h200 : 10'h1FF;
        bus.out_ready = 1'b1;
        send_block("signed");
        read_block("signed");

        // Mid-block reset: 5 rows, reset, then a block of all 7
        for (int r = 0; r < 8; r++)
            for (int k = 0; k < 8; k++) blk[r][k] = SIZE'(8*r + k);
        for (int r = 0; r < 5; r++) begin
            @(negedge clk);
            bus.in_valid = 1'b1;
            bus.in_row   = row_of(r);
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        check("mid_rst_valid", bus.out_valid, 1'b0);
        for (int r = 0; r < 8; r++)
            for (int k = 0; k < 8; k++) blk[r][k] = SIZE'(7);
        send_block("mid");
        read_block("mid");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
